// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding one UART transmitter
// Whole packets stay with one requester; an idle locked requester is released after LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   timeout_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LOCK_TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic [1:0]         r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_gidx;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]         r_hold_data;
    logic               r_hold_last;
    logic [CW-1:0]      r_cnt;
    logic               r_timeout;

    logic               w_found;
    logic [IW-1:0]      w_sel;
    logic               w_accept;
    logic [IW-1:0]      w_acc_idx;
    logic [IW-1:0]      w_ptr_next;

    // Scan from the farthest offset down so the nearest valid requester at/after rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_sel   = IW'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_accept    = 1'b0;
        w_acc_idx   = w_sel;
        req_ready_o = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready_o[w_sel] = 1'b1;
                    w_accept           = 1'b1;
                end
            end
            ST_LOCK: begin
                req_ready_o = r_grant;
                w_accept    = req_valid_i[r_gidx];
                w_acc_idx   = r_gidx;
            end
            default: ;
        endcase
    end

    assign w_ptr_next = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    assign tx_valid_o = (r_state == ST_SEND);
    assign tx_data_o  = r_hold_data;
    assign grant_o    = r_grant;
    assign timeout_o  = r_timeout;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_hold_data <= 8'h00;
            r_hold_last <= 1'b0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hold_data <= req_data_i[8*w_acc_idx +: 8];
                        r_hold_last <= req_last_i[w_acc_idx];
                        r_gidx      <= w_acc_idx;
                        r_grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_acc_idx;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready_i) begin
                        if (r_hold_last) begin
                            r_state  <= ST_IDLE;
                            r_grant  <= '0;
                            r_rr_ptr <= w_ptr_next;
                        end else begin
                            r_state <= ST_LOCK;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_accept) begin
                        r_hold_data <= req_data_i[8*w_acc_idx +: 8];
                        r_hold_last <= req_last_i[w_acc_idx];
                        r_state     <= ST_SEND;
                    end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= '0;
                        r_rr_ptr  <= w_ptr_next;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// A packet-level ownership model is checked every cycle; directed scenarios add literal expectations.
module tb_uart_tx_arbiter;

    localparam int N = 3;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic [N-1:0]   grant;
    logic           timeout;

    int n_checks = 0;
    int n_fail = 0;

    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_idle = 0;
    bit         m_busy = 1'b0;
    bit         m_locked = 1'b0;
    bit         m_last = 1'b0;
    bit         m_tpulse = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] tx_log[$];
    logic [7:0] seq1[3];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(T)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .timeout_o   (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return N'(1) << ((ptr + i) % N);
        return '0;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Model: who owns the transmitter, whether a byte is in flight, and whose turn is next.
    always @(negedge clk) begin : cmp
        logic [N-1:0] exp_ready;
        logic [N-1:0] acc;
        if (!rstn) begin
            m_owner = -1; m_ptr = 0; m_idle = 0; m_busy = 0;
            m_locked = 0; m_tpulse = 0; m_byte = 8'h00;
        end
        exp_ready = m_busy ? '0 : (m_locked ? (N'(1) << m_owner) : pick(req_valid, m_ptr));
        chk("ready", req_ready, exp_ready);
        chk("tx_valid", tx_valid, m_busy);
        if (m_busy) chk("tx_data", tx_data, m_byte);
        chk("grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("timeout", timeout, m_tpulse);
        if (rstn) begin
            m_tpulse = 0;
            acc = exp_ready & req_valid;
            if (m_busy) begin
                if (tx_ready) begin
                    tx_log.push_back(m_byte);
                    m_busy = 0;
                    if (m_last) begin
                        m_ptr = (m_owner + 1) % N;
                        m_owner = -1;
                    end else begin
                        m_locked = 1;
                        m_idle = 0;
                    end
                end
            end else if (acc != '0) begin
                m_busy = 1;
                m_locked = 0;
                m_owner = idx_of(acc);
                m_byte = req_data[8*m_owner +: 8];
                m_last = req_last[m_owner];
            end else if (m_locked) begin
                if (m_idle == T - 1) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_tpulse = 1;
                end else begin
                    m_idle++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int idx;
        bit hs;
        seq1[0] = 8'h10; seq1[1] = 8'h11; seq1[2] = 8'h12;

        tick();
        tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant", grant, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ready", req_ready, 0);
        rstn = 1'b1;
        tick();

        // single byte
        tx_ready = 1'b1;
        req_data = 24'h000041; req_last = 3'b001; req_valid = 3'b001;
        #1 chk("t1_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("t1_txv", tx_valid, 1);
        chk("t1_data", tx_data, 8'h41);
        chk("t1_grant", grant, 3'b001);
        tick();
        chk("t1_txv_off", tx_valid, 0);
        chk("t1_grant_off", grant, 0);
        req_valid = 3'b011; req_last = 3'b011;
        #1 chk("t1_ptr", req_ready, 3'b010);
        req_valid = '0;
        tick();
        chk("t1_log_n", tx_log.size(), 1);
        chk("t1_log0", tx_log[0], 8'h41);

        // round robin
        do_reset();
        tx_log.delete();
        req_data = 24'hA2A1A0; req_last = 3'b111; req_valid = 3'b111;
        repeat (8) tick();
        req_valid = '0;
        chk("t2_log_n", tx_log.size(), 4);
        chk("t2_log0", tx_log[0], 8'hA0);
        chk("t2_log1", tx_log[1], 8'hA1);
        chk("t2_log2", tx_log[2], 8'hA2);
        chk("t2_log3", tx_log[3], 8'hA0);

        // packet lock
        do_reset();
        tx_log.delete();
        req_data = 24'h020001; req_last = 3'b101; req_valid = 3'b101;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid[1] = (idx < 3);
            if (idx < 3) req_data[15:8] = seq1[idx];
            req_last[1] = (idx == 2);
            #1;
            hs = req_valid[1] & req_ready[1];
            tick();
            if (hs) idx++;
        end
        req_valid = '0;
        chk("t3_sent", idx, 3);
        chk("t3_log_n", tx_log.size() >= 6, 1);
        chk("t3_log0", tx_log[0], 8'h01);
        chk("t3_log1", tx_log[1], 8'h10);
        chk("t3_log2", tx_log[2], 8'h11);
        chk("t3_log3", tx_log[3], 8'h12);
        chk("t3_log4", tx_log[4], 8'h02);
        chk("t3_log5", tx_log[5], 8'h01);

        // backpressure
        do_reset();
        tx_log.delete();
        tx_ready = 1'b0;
        req_data = 24'h00005A; req_last = 3'b001; req_valid = 3'b001;
        tick();
        req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            chk("t4_hold_v", tx_valid, 1);
            chk("t4_hold_d", tx_data, 8'h5A);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        chk("t4_txv_off", tx_valid, 0);
        repeat (3) tick();
        chk("t4_log_n", tx_log.size(), 1);
        chk("t4_log0", tx_log[0], 8'h5A);

        // lock timeout
        do_reset();
        tx_log.delete();
        tx_ready = 1'b1;
        req_data = 24'h330000; req_last = 3'b000; req_valid = 3'b100;
        tick();
        req_valid = '0;
        tick();
        for (int c = 0; c < T; c++) begin
            chk("t5_no_to", timeout, 0);
            chk("t5_grant", grant, 3'b100);
            tick();
        end
        chk("t5_to", timeout, 1);
        chk("t5_grant_off", grant, 0);
        tick();
        chk("t5_to_off", timeout, 0);
        req_valid = 3'b011; req_last = 3'b011;
        #1 chk("t5_ptr", req_ready, 3'b001);
        req_valid = '0;
        chk("t5_log0", tx_log[0], 8'h33);

        // accept on the timeout cycle wins
        tick();
        req_data = 24'h330000; req_last = 3'b000; req_valid = 3'b100;
        tick();
        req_valid = '0;
        tick();
        repeat (T - 1) tick();
        req_data = 24'h440000; req_last = 3'b100; req_valid = 3'b100;
        #1 chk("t5b_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        chk("t5b_no_to", timeout, 0);
        chk("t5b_txv", tx_valid, 1);
        chk("t5b_data", tx_data, 8'h44);
        tick();

        // async reset during SEND
        do_reset();
        tx_log.delete();
        tx_ready = 1'b0;
        req_data = 24'h007700; req_last = 3'b010; req_valid = 3'b010;
        tick();
        req_valid = '0;
        chk("t6_txv", tx_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_txv_rst", tx_valid, 0);
        chk("t6_grant_rst", grant, 0);
        chk("t6_data_rst", tx_data, 8'h00);
        tick();
        rstn = 1'b1;
        tx_ready = 1'b1;
        repeat (6) tick();
        chk("t6_log_n", tx_log.size(), 0);
        chk("t6_txv_after", tx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of byte requesters (2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, maximum idle cycles a locked requester keeps the grant (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester byte-valid.
REQ-006 SHALL have port req_data_i  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 SHALL have port req_last_i  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid_i.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  per-requester byte accepted when high with req_valid_i.
REQ-009 SHALL have port tx_data_o  output  8  byte to the UART transmitter.
REQ-010 SHALL have port tx_valid_o  output  1  byte offered to the transmitter.
REQ-011 SHALL have port tx_ready_i  input  1  transmitter accepts byte when high with tx_valid_o.
REQ-012 SHALL have port grant_o  output  NUM_REQ  one-hot current owner; all-zero when unowned.
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse on lock timeout release.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, LOCK.
REQ-015 IDLE: if any req_valid_i bit set, select first set bit at or after rr_ptr (modulo NUM_REQ); assert req_ready_o for that bit only, same cycle (combinational from req_valid_i and rr_ptr).
REQ-016 IDLE accept: capture byte and last flag into holding registers, register grant_o one-hot, go to SEND.
REQ-017 IDLE with no valid: req_ready_o=0, grant_o=0, stay.
REQ-018 SEND: tx_valid_o=1, tx_data_o=held byte, stable until tx_ready_i; req_ready_o all zero.
REQ-019 SEND handshake with held last=1: go IDLE, grant_o=0, rr_ptr=(g+1) mod NUM_REQ, g = granted index.
REQ-020 SEND handshake with held last=0: go LOCK, clear timeout counter.
REQ-021 LOCK: req_ready_o[g]=1 only; other requesters ignored regardless of valid.
REQ-022 LOCK accept from g: capture byte/last, go SEND next cycle; byte-to-tx_valid_o latency one cycle.
REQ-023 LOCK idle: counter increments per cycle; at count LOCK_TIMEOUT-1 without accept: go IDLE, grant_o=0, rr_ptr=(g+1) mod NUM_REQ, timeout_o=1 for that one cycle.
REQ-024 Accept and timeout in same LOCK cycle: accept wins, no timeout_o.
REQ-025 tx_valid_o SHALL never deassert before handshake; tx_data_o unchanged while tx_valid_o high.
REQ-026 At most one req_ready_o bit high in any cycle; req_ready_o never high in SEND.
REQ-027 rr_ptr wraps from NUM_REQ-1 to 0.
REQ-028 Max throughput: one byte per two cycles with tx_ready_i tied high.

Reset
REQ-029 rstn_i low asynchronously forces IDLE, rr_ptr=0, counter=0, holding byte=8'h00, tx_valid_o=0, tx_data_o=8'h00, grant_o=0, timeout_o=0; req_ready_o follows IDLE rule.
REQ-030 Reset mid-SEND or mid-LOCK discards held byte; no byte emitted after release until a new accept.

Verification
REQ-031 Single byte: req0 valid, data 8'h41, last=1, tx_ready_i=1 -> req_ready_o=3'b001 cycle 0, tx_valid_o with 8'h41 cycle 1, IDLE cycle 2, rr_ptr=1.
REQ-032 Round robin: all three requesters continuously valid, last=1, data 8'hA0/A1/A2 -> tx order A0,A1,A2,A0.
REQ-033 Packet lock: req1 sends 8'h10,8'h11,8'h12 (last on 8'h12) while req0/req2 valid -> three req1 bytes contiguous before any other byte.
REQ-034 Backpressure: tx_ready_i low 20 cycles during SEND with 8'h5A -> tx_valid_o and 8'h5A held all 20 cycles, exactly one transfer.
REQ-035 Timeout: LOCK_TIMEOUT=16, req2 sends 8'h33 last=0 then goes idle -> timeout_o pulse 16 cycles after LOCK entry, grant_o=0, rr_ptr=0.
REQ-036 Async reset asserted during SEND with tx_ready_i low -> tx_valid_o and grant_o zero immediately, no transfer after release.
